// File: rtl/button_pkg.sv
// button_pkg: shared constants and helpers for the button conditioner.
// Optional long-press logic is built when BUTTON_LONG_PRESS_EN is defined.
package button_pkg;

  localparam int unsigned BTN_DEBOUNCE_DEFAULT   = 50000;
  localparam int unsigned BTN_LONG_PRESS_DEFAULT = 5_000_000;

  function automatic int btn_cnt_width(input longint unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/button_debounce_channel.sv
// button_debounce_channel: one pad synchroniser, debouncer and event pulser.
// Hold counter and long_press pulse exist only with BUTTON_LONG_PRESS_EN.
module button_debounce_channel
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = BTN_DEBOUNCE_DEFAULT,
  parameter int unsigned CNT_W             = 16,
  parameter bit          ACTIVE_LOW        = 1'b0,
  parameter int unsigned LONG_PRESS_CYCLES = BTN_LONG_PRESS_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic button,
  output logic pressed,
  output logic released,
  output logic long_press
);

  localparam logic IDLE = ACTIVE_LOW;
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  if (LONG_PRESS_CYCLES == 0) begin : g_chk_lp
    $error("LONG_PRESS_CYCLES must be at least 1");
  end

  logic             sync1;
  logic             sync2;
  logic             lvl;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= IDLE;
      sync2 <= IDLE;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  assign lvl = sync2 ^ ACTIVE_LOW;

  // Any matching cycle restarts qualification of the new level.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      button   <= 1'b0;
      pressed  <= 1'b0;
      released <= 1'b0;
    end else begin
      pressed  <= 1'b0;
      released <= 1'b0;
      if (lvl == button) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        cnt      <= '0;
        button   <= lvl;
        pressed  <= lvl;
        released <= ~lvl;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

`ifdef BUTTON_LONG_PRESS_EN
  localparam int HOLD_W = btn_cnt_width(LONG_PRESS_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_MAX =
    HOLD_W'(LONG_PRESS_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_ARM =
    HOLD_W'(LONG_PRESS_CYCLES - 1);

  logic [HOLD_W-1:0] hold;

  // Saturation at HOLD_MAX gives one pulse per press.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold       <= '0;
      long_press <= 1'b0;
    end else begin
      long_press <= button && (hold == HOLD_ARM);
      if (!button) begin
        hold <= '0;
      end else if (hold != HOLD_MAX) begin
        hold <= hold + HOLD_W'(1);
      end
    end
  end
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: per-pin synchronise + debounce for the LED/button block.
// Define BUTTON_LONG_PRESS_EN to build the long_press hold counters.
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned NUM_BUTTONS       = 3,
  parameter int unsigned DEBOUNCE_CYCLES   = BTN_DEBOUNCE_DEFAULT,
  parameter int unsigned CNT_W             = 16,
  parameter bit          ACTIVE_LOW        = 1'b0,
  parameter int unsigned LONG_PRESS_CYCLES = BTN_LONG_PRESS_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] raw_buttons,
  output logic [NUM_BUTTONS-1:0] buttons,
  output logic [NUM_BUTTONS-1:0] pressed,
  output logic [NUM_BUTTONS-1:0] released,
  output logic [NUM_BUTTONS-1:0] long_press
);

  if (NUM_BUTTONS == 0) begin : g_chk_num
    $error("NUM_BUTTONS must be at least 1");
  end

  if (DEBOUNCE_CYCLES == 0) begin : g_chk_zero
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  if (longint'(DEBOUNCE_CYCLES) > (longint'(1) << CNT_W))
  begin : g_chk_width
    $error("DEBOUNCE_CYCLES does not fit in CNT_W");
  end

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
    button_debounce_channel #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .CNT_W            (CNT_W),
      .ACTIVE_LOW       (ACTIVE_LOW),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .raw       (raw_buttons[i]),
      .button    (buttons[i]),
      .pressed   (pressed[i]),
      .released  (released[i]),
      .long_press(long_press[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: window-rule reference model with scoreboard checking.
// Active-high and active-low instances see complementary pads.
module tb_button_conditioner;

  localparam int NB   = 3;
  localparam int D    = 4;
  localparam int LP   = 10;
  localparam int MAXC = 16384;

  typedef struct packed {
    logic [NB-1:0] b;
    logic [NB-1:0] p;
    logic [NB-1:0] r;
    logic [NB-1:0] l;
  } obs_t;

  logic          clk;
  logic          reset;
  logic [NB-1:0] raw;
  logic [NB-1:0] raw_n;
  logic [NB-1:0] b_hi, p_hi, r_hi, l_hi;
  logic [NB-1:0] b_lo, p_lo, r_lo, l_lo;

  int n_cmp = 0;
  int n_bad = 0;

  assign raw_n = ~raw;

  button_conditioner #(
    .NUM_BUTTONS(NB), .DEBOUNCE_CYCLES(D), .CNT_W(3),
    .ACTIVE_LOW(1'b0), .LONG_PRESS_CYCLES(LP)
  ) u_hi (
    .clk(clk), .reset(reset), .raw_buttons(raw),
    .buttons(b_hi), .pressed(p_hi),
    .released(r_hi), .long_press(l_hi)
  );

  button_conditioner #(
    .NUM_BUTTONS(NB), .DEBOUNCE_CYCLES(D), .CNT_W(3),
    .ACTIVE_LOW(1'b1), .LONG_PRESS_CYCLES(LP)
  ) u_lo (
    .clk(clk), .reset(reset), .raw_buttons(raw_n),
    .buttons(b_lo), .pressed(p_lo),
    .released(r_lo), .long_press(l_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference: an output flips when the level seen through the
  // two-flop delay has disagreed with it for the last D edges and
  // it has not changed (or been reset) within those D edges.
  obs_t          expq[$];
  logic [NB-1:0] hist[MAXC];
  logic [NB-1:0] mb;
  int            last_chg[NB];
  int            rise_e[NB];
  int            e = 2;

  task automatic model_step();
    obs_t x;
    logic ok;
    x = '0;
    if (reset) begin
      hist[e]   = '0;
      hist[e-1] = '0;
      mb        = '0;
      for (int c = 0; c < NB; c++) begin
        last_chg[c] = e;
        rise_e[c]   = -1;
      end
    end else begin
      hist[e] = raw;
      for (int c = 0; c < NB; c++) begin
        ok = 1'b0;
        if (e - last_chg[c] >= D) begin
          ok = 1'b1;
          for (int j = e - D + 1; j <= e; j++)
            if (hist[j-2][c] == mb[c]) ok = 1'b0;
        end
`ifdef BUTTON_LONG_PRESS_EN
        if (mb[c] && rise_e[c] >= 0 && e == rise_e[c] + LP)
          x.l[c] = 1'b1;
`endif
        if (ok) begin
          last_chg[c] = e;
          if (mb[c]) begin
            x.r[c]    = 1'b1;
            rise_e[c] = -1;
          end else begin
            x.p[c]    = 1'b1;
            rise_e[c] = e;
          end
          mb[c] = ~mb[c];
        end
      end
    end
    x.b = mb;
    expq.push_back(x);
    e++;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    obs_t x;
    @(negedge clk);
    if (expq.size() > 0) begin
      x = expq.pop_front();
      check("scoreboard hi",
            32'({b_hi, p_hi, r_hi, l_hi}), 32'(x));
      check("scoreboard lo",
            32'({b_lo, p_lo, r_lo, l_lo}), 32'(x));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called right after raw[ch] changed at a negedge.
  task automatic rise_check(input int ch, input string nm);
    for (int i = 0; i < D + 1; i++) begin
      @(posedge clk); #1;
      check({nm, " early"},
            32'({b_hi[ch], b_lo[ch]}), 32'd0);
    end
    @(posedge clk); #1;
    check({nm, " rise"},
          32'({b_hi[ch], p_hi[ch], b_lo[ch], p_lo[ch]}), 32'hf);
    @(negedge clk);
  endtask

  initial begin
    int np;
    int at;
    reset = 1'b1;
    raw   = '0;
    cyc(3);
    check("reset outs hi", 32'({b_hi, p_hi, r_hi, l_hi}), 32'd0);
    check("reset outs lo", 32'({b_lo, p_lo, r_lo, l_lo}), 32'd0);
    reset = 1'b0;
    cyc(8);
    check("idle lo", 32'({b_lo, p_lo, r_lo, l_lo}), 32'd0);

    raw[0] = 1'b1;
    rise_check(0, "clean press");
    cyc(10);
    raw[0] = 1'b0;
    cyc(10);

    for (int k = 0; k < 4; k++) begin
      raw[1] = (k % 2 == 0);
      cyc(3);
    end
    check("bounce no change", 32'({b_hi[1], b_lo[1]}), 32'd0);
    raw[1] = 1'b1;
    rise_check(1, "bounce press");
    cyc(5);
    raw[1] = 1'b0;
    cyc(10);

    raw[2] = 1'b1;
    rise_check(2, "active low press");
    cyc(5);
    raw[2] = 1'b0;
    cyc(10);

    raw[2] = 1'b1;
    cyc(4);
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid-qual reset", 32'({b_hi, p_hi, r_hi, b_lo}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    rise_check(2, "requalify");
    cyc(5);
    raw = '0;
    cyc(10);

    raw = 3'b111;
    repeat (D + 2) @(posedge clk);
    #1;
    check("simul press", 32'({p_hi, r_hi}), 32'h38);
    cyc(10);
    raw = 3'b000;
    repeat (D + 2) @(posedge clk);
    #1;
    check("simul release", 32'({p_hi, r_hi}), 32'h07);
    cyc(10);

    for (int rep = 0; rep < 2; rep++) begin
      np = 0;
      at = 0;
      raw[0] = 1'b1;
      for (int i = 1; i <= 30; i++) begin
        @(posedge clk); #1;
        if (l_hi[0]) begin
          np++;
          at = i;
        end
      end
`ifdef BUTTON_LONG_PRESS_EN
      check("long press count", 32'(np), 32'd1);
      check("long press edge", 32'(at), 32'(D + 2 + LP));
`else
      check("long press off", 32'(np), 32'd0);
`endif
      @(negedge clk);
      raw[0] = 1'b0;
      cyc(12);
    end

    for (int i = 0; i < 4000; i++) begin
      for (int c = 0; c < NB; c++)
        if ($urandom_range(0, 7) == 0) raw[c] = ~raw[c];
      reset = ($urandom_range(0, 299) == 0);
      cyc(1);
    end
    reset = 1'b0;
    raw   = '0;
    cyc(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Input conditioning stage directly upstream of the Wishbone LED/button peripheral. It synchronises raw, bouncing push-button pins into the `clk` domain and debounces each one independently. It drives the peripheral's `buttons` input with clean, active-high levels. It also produces one-cycle press and release event pulses for local logic.

## Interface
Parameters:
- `NUM_BUTTONS`, default 3: number of independent button channels (≥1).
- `DEBOUNCE_CYCLES`, default 16'd50000: consecutive stable cycles required before an output level changes (≥1).
- `CNT_W`, default 16: debounce counter width; `DEBOUNCE_CYCLES` must be ≤ 2^`CNT_W`.
- `ACTIVE_LOW`, default 0: 1 means raw pins read 0 when pressed. Inversion happens after the synchroniser.
- `LONG_PRESS_CYCLES`, default 32'd5_000_000: hold duration for a long-press event (only with `BUTTON_LONG_PRESS_EN`).

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  reset, synchronous, active-high.
- `raw_buttons`  in  `NUM_BUTTONS`  asynchronous pad inputs.
- `buttons`  out  `NUM_BUTTONS`  debounced level, active-high; connects to the peripheral's `buttons` input.
- `pressed`  out  `NUM_BUTTONS`  one-cycle pulse on a debounced 0→1 transition.
- `released`  out  `NUM_BUTTONS`  one-cycle pulse on a debounced 1→0 transition.
- `long_press`  out  `NUM_BUTTONS`  one-cycle pulse after a sustained press (only with `BUTTON_LONG_PRESS_EN`).

## Operation
Each channel has the same structure and no cross-channel interaction:
- **Synchroniser:** two flops, `sync1` → `sync2`. Reset value is the raw inactive level: all-ones if `ACTIVE_LOW`, else zero. `lvl` = `sync2` XOR `ACTIVE_LOW`.
- **Debounce counter `cnt` (`CNT_W` bits):**
  - If `lvl` equals `buttons`: `cnt` ← 0.
  - On a mismatch with `cnt` < `DEBOUNCE_CYCLES-1`: `cnt` ← `cnt`+1.
  - On a mismatch with `cnt` == `DEBOUNCE_CYCLES-1`: `buttons` ← `lvl` and `cnt` ← 0.
- **Bounce rejection:** any single matching cycle restarts the qualification. A glitch shorter than `DEBOUNCE_CYCLES` cycles never reaches `buttons`.
- **Event pulses:**
  - `pressed`/`released` are registered and assert on the same edge that `buttons` changes. They are high for exactly one cycle.
  - They cannot both be high on the same channel in the same cycle.
- **Reset:** dominates everything, including mid-qualification and mid-hold. After reset:
  - `buttons`, `pressed`, `released`, `long_press`, `cnt` and the hold counter are all 0.
  - A button physically held through reset is reported as a press `DEBOUNCE_CYCLES+2` edges after reset deasserts. This is intended.
- **Counter behaviour:** no counter wraps. `cnt` never exceeds `DEBOUNCE_CYCLES-1`.

## Timing
- **Latency:** raw change first sampled at edge k → `buttons` and the event pulse update at edge k+1+`DEBOUNCE_CYCLES`.
  - That is `DEBOUNCE_CYCLES`+2 edges including k.
  - Example: `DEBOUNCE_CYCLES`=1 gives 3 edges.
- **Throughput:** edges closer together than the latency are filtered, not queued.
- **Simultaneous events:** channels qualify in parallel. Simultaneous presses on several channels pulse in the same cycle.
- **Outputs:** all outputs come directly from flops.

## Configuration
- `BUTTON_LONG_PRESS_EN` defined: each channel adds a saturating hold counter of width $clog2(`LONG_PRESS_CYCLES`+1).
  - The counter clears while `buttons`=0 and increments each edge while `buttons`=1.
  - `long_press` pulses for one cycle on the edge where the counter becomes `LONG_PRESS_CYCLES`, i.e. `LONG_PRESS_CYCLES` edges after `buttons` rose.
  - It pulses at most once per press and re-arms after release.
- `BUTTON_LONG_PRESS_EN` undefined: hold counters are not built and `long_press` is tied to 0.

## Structure
- Shared package `button_pkg`:
  - Default constants `BTN_DEBOUNCE_DEFAULT` and `BTN_LONG_PRESS_DEFAULT`.
  - Function `btn_cnt_width(n)` returning $clog2(n+1).
- Sub-module `button_debounce_channel`: one channel (synchroniser, debounce counter, event pulses, optional hold counter). It is instantiated `NUM_BUTTONS` times via generate.
- Top level: parameter checks (elaboration error if `DEBOUNCE_CYCLES`=0 or `DEBOUNCE_CYCLES` > 2^`CNT_W`) plus bus slicing.

## Test plan
- **Clean press:** `DEBOUNCE_CYCLES`=4, raw[0] 0→1 held → `buttons[0]` rises 6 edges after the first sampling edge, with a single `pressed[0]` pulse on that same edge.
- **Bounce rejection:** `DEBOUNCE_CYCLES`=4, raw[1] toggles 1,0,1,0 at 3-cycle intervals, then holds 1 → no output change during bouncing; one `pressed[1]` pulse 6 edges after the final rise.
- **Active-low plus reset:** `ACTIVE_LOW`=1, raw idle at all-ones through reset → all outputs 0 and no events. Then raw[2]=0 held → `buttons[2]`=1 after 6 edges.
- **Reset mid-qualification:** assert reset with `cnt`=2 → all outputs and counters 0 next edge. After release, a still-pressed button re-qualifies after the full 6 edges.
- **Simultaneous:** raw[2:0] 000→111 on one edge → `pressed`=111 in the same cycle. Release later → `released`=111 in one cycle, never overlapping `pressed`.
- **Long press** (`BUTTON_LONG_PRESS_EN`, `LONG_PRESS_CYCLES`=10): hold 30 cycles → exactly one `long_press[0]` pulse 10 edges after `buttons[0]` rose. Release and re-press → the pulse repeats. With the macro undefined, `long_press` stays 0.
